mem_stage_completion_buffer: RTL and testbench

// - Parametrised successor to the MEM-stage glue. Buffers up to DEPTH in-flight EX results.
// - Pairs in-order D-cache responses with their memory ops.
// - Aligns and extends load data by size and offset.
// - Retires entries to writeback in program order, one per cycle.
// - Sits between the EX-stage glue and the register-file writeback port.
// - Replaces the single-entry done/select logic so the pipeline can run with a non-blocking D-cache.

---
 rtl/mem_stage_completion_buffer.sv | 146 ++++++++++++++
 tb/tb_mem_stage_completion_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_completion_buffer.sv
// MEM-stage completion buffer: holds in-flight EX results, pairs in-order D-cache
// responses with their memory ops, formats load data and retires in program order.
module mem_stage_completion_buffer #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int DEPTH          = 4,
    localparam int OFF_W          = $clog2(DATA_WIDTH / 8),
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_mem_access,
    input  logic                      in_is_load,
    input  logic [1:0]                in_ld_size,
    input  logic                      in_ld_signed,
    input  logic [OFF_W-1:0]          in_byte_off,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic                      in_uses_rw,
    input  logic [REG_ADDR_WIDTH-1:0] in_rw_addr,
    input  logic                      cache_resp_valid,
    input  logic [DATA_WIDTH-1:0]     cache_resp_data,
    output logic                      wb_valid,
    output logic                      wb_uses_rw,
    output logic [REG_ADDR_WIDTH-1:0] wb_rw_addr,
    output logic [DATA_WIDTH-1:0]     wb_rw_data,
    output logic [CNT_W-1:0]          occupancy,
    output logic                      resp_err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic                      is_mem;
        logic                      is_load;
        logic [1:0]                ld_size;
        logic                      ld_signed;
        logic [OFF_W-1:0]          byte_off;
        logic                      uses_rw;
        logic [REG_ADDR_WIDTH-1:0] rw_addr;
    } entry_t;

    entry_t                ent      [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_rdy;
    logic [PTR_W-1:0]      head, tail, tgt;
    logic [CNT_W-1:0]      count;
    logic                  hit, resp_hit, tgt_is_head, retire, enq;
    logic [DATA_WIDTH-1:0] resp_word, head_data;

    // Select the lane, then mask to the access size and sign- or zero-extend.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [1:0]            size,
        input logic                  sgn,
        input logic [OFF_W-1:0]      off
    );
        logic [OFF_W-1:0]      lane;
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] mask;
        logic                  msb;
        case (size)
            2'b00:   lane = off;
            2'b01:   lane = off & ~OFF_W'(1);
            2'b10:   lane = off & ~OFF_W'(3);
            default: lane = '0;
        endcase
        shifted = raw >> {lane, 3'b000};
        case (size)
            2'b00:   begin mask = DATA_WIDTH'(8'hFF);         msb = shifted[7];  end
            2'b01:   begin mask = DATA_WIDTH'(16'hFFFF);      msb = shifted[15]; end
            2'b10:   begin mask = DATA_WIDTH'(32'hFFFF_FFFF); msb = shifted[31]; end
            default: begin mask = '1;                         msb = 1'b0;        end
        endcase
        return (shifted & mask) | ((sgn && msb) ? ~mask : '0);
    endfunction

    assign in_ready  = !rst && (count != CNT_W'(DEPTH));
    assign enq       = in_valid && in_ready;
    assign occupancy = count;

    // Oldest valid memory entry still waiting for its response.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit = 1'b0;
        tgt = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && (CNT_W'(i) < count) && ent[head + PTR_W'(i)].is_mem
                && !ent_rdy[head + PTR_W'(i)]) begin
                hit = 1'b1;
                tgt = head + PTR_W'(i);
            end
        end
    end

    assign resp_hit    = cache_resp_valid && hit;
    assign resp_word   = ent[tgt].is_load
                       ? format_load(cache_resp_data, ent[tgt].ld_size,
                                     ent[tgt].ld_signed, ent[tgt].byte_off)
                       : ent_data[tgt];
    assign tgt_is_head = resp_hit && (tgt == head);
    assign retire      = (count != '0) && (ent_rdy[head] || tgt_is_head);
    assign head_data   = tgt_is_head ? resp_word : ent_data[head];

    // NOTE: entry payload has no reset; ent_rdy and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent[tail]      <= '{is_mem: in_is_mem_access, is_load: in_is_load,
                                ld_size: in_ld_size, ld_signed: in_ld_signed,
                                byte_off: in_byte_off, uses_rw: in_uses_rw,
                                rw_addr: in_rw_addr};
            ent_data[tail] <= in_alu_result;
        end
        if (resp_hit) ent_data[tgt] <= resp_word;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_rdy    <= '0;
            wb_valid   <= 1'b0;
            wb_uses_rw <= 1'b0;
            wb_rw_addr <= '0;
            wb_rw_data <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (enq) begin
                ent_rdy[tail] <= !in_is_mem_access;
                tail          <= tail + PTR_W'(1);
            end
            if (resp_hit)              ent_rdy[tgt] <= 1'b1;
            else if (cache_resp_valid) resp_err     <= 1'b1;
            wb_valid <= retire;
            if (retire) begin
                wb_uses_rw <= ent[head].uses_rw;
                wb_rw_addr <= ent[head].rw_addr;
                wb_rw_data <= head_data;
                head       <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(retire);
        end
    end
endmodule

// File: tb/tb_mem_stage_completion_buffer.sv
// Directed bench for mem_stage_completion_buffer with hand-computed expectations.
module tb_mem_stage_completion_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_mem_access, in_is_load, in_ld_signed, in_uses_rw;
    logic [1:0]  in_ld_size, in_byte_off;
    logic [31:0] in_alu_result, cache_resp_data, wb_rw_data;
    logic [4:0]  in_rw_addr, wb_rw_addr;
    logic        cache_resp_valid, wb_valid, wb_uses_rw, resp_err;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_completion_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_mem_access(in_is_mem_access), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_byte_off(in_byte_off),
        .in_alu_result(in_alu_result), .in_uses_rw(in_uses_rw), .in_rw_addr(in_rw_addr),
        .cache_resp_valid(cache_resp_valid), .cache_resp_data(cache_resp_data),
        .wb_valid(wb_valid), .wb_uses_rw(wb_uses_rw), .wb_rw_addr(wb_rw_addr),
        .wb_rw_data(wb_rw_data), .occupancy(occupancy), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mem, input logic ld, input logic [1:0] size,
                        input logic sgn, input logic [1:0] off, input logic [31:0] alu,
                        input logic uses, input logic [4:0] addr);
        in_valid = 1'b1; in_is_mem_access = mem; in_is_load = ld; in_ld_size = size;
        in_ld_signed = sgn; in_byte_off = off; in_alu_result = alu;
        in_uses_rw = uses; in_rw_addr = addr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] data);
        cache_resp_valid = 1'b1; cache_resp_data = data;
        tick();
        cache_resp_valid = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, ".valid"}, wb_valid, 1);
        check({tag, ".addr"}, wb_rw_addr, addr);
        check({tag, ".data"}, wb_rw_data, data);
    endtask

    // Fill-test vectors: size, signed, offset, response word, expected writeback data.
    logic [1:0]  f_size [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic        f_sgn  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  f_off  [4] = '{2'd0, 2'd3, 2'd3, 2'd1};
    logic [31:0] f_resp [4] = '{32'h8000_0001, 32'hCAFE_BABE, 32'hA500_0000, 32'h1234_8001};
    logic [31:0] f_exp  [4] = '{32'h8000_0001, 32'hCAFE_BABE, 32'h0000_00A5, 32'hFFFF_8001};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_mem_access = 1'b0; in_is_load = 1'b0;
        in_ld_size = 2'b00; in_ld_signed = 1'b0; in_byte_off = 2'd0; in_alu_result = '0;
        in_uses_rw = 1'b0; in_rw_addr = '0; cache_resp_valid = 1'b0; cache_resp_data = '0;
        tick(); tick();
        check("rst.in_ready", in_ready, 0);
        rst = 1'b0; #1;
        check("rst.occ", occupancy, 0);
        check("rst.wb_valid", wb_valid, 0);
        check("rst.wb_data", wb_rw_data, 0);
        check("rst.resp_err", resp_err, 0);
        check("rst.in_ready_after", in_ready, 1);

        // 1: non-mem op retires the cycle after it is enqueued
        push(0, 0, 2'b00, 0, 0, 32'h1234, 1, 5'd5);
        check("t1.occ_enq", occupancy, 1);
        check("t1.no_wb_yet", wb_valid, 0);
        tick();
        check_wb("t1.wb", 5'd5, 32'h1234);
        check("t1.uses_rw", wb_uses_rw, 1);
        check("t1.occ", occupancy, 0);
        tick();
        check("t1.wb_drop", wb_valid, 0);
        check("t1.wb_hold", wb_rw_data, 32'h1234);

        // 2: signed byte load, lane 2 of 0x0080_FF00 is 0x80
        push(1, 1, 2'b00, 1, 2'd2, 32'h100, 1, 5'd6);
        tick();
        check("t2.wait", wb_valid, 0);
        check("t2.occ", occupancy, 1);
        resp(32'h0080_FF00);
        check_wb("t2.wb", 5'd6, 32'hFFFF_FF80);
        check("t2.occ_after", occupancy, 0);

        // 3: pending load holds a younger ALU op; unsigned half at off 3 uses lane 2
        push(1, 1, 2'b01, 0, 2'd3, 32'h200, 1, 5'd7);
        push(0, 0, 2'b00, 0, 0, 32'hAAAA, 1, 5'd8);
        tick();
        check("t3.held", wb_valid, 0);
        check("t3.occ", occupancy, 2);
        resp(32'hBEEF_0000);
        check_wb("t3.load", 5'd7, 32'h0000_BEEF);
        tick();
        check_wb("t3.alu", 5'd8, 32'hAAAA);
        tick();
        check("t3.idle", wb_valid, 0);

        // store: response does not overwrite the address-path data
        push(1, 0, 2'b10, 0, 0, 32'hDEAD_0000, 0, 5'd0);
        resp(32'hFFFF_FFFF);
        check_wb("st.wb", 5'd0, 32'hDEAD_0000);
        check("st.uses_rw", wb_uses_rw, 0);

        // 4: fill, then back-to-back responses retire in order
        for (int k = 0; k < 4; k++)
            push(1, 1, f_size[k], f_sgn[k], f_off[k], 32'h300 + 32'(k), 1, 5'(10 + k));
        check("t4.full_ready", in_ready, 0);
        check("t4.full_occ", occupancy, 4);
        in_valid = 1'b1; in_is_mem_access = 1'b0; in_rw_addr = 5'd20;
        for (int k = 0; k < 4; k++) begin
            resp(f_resp[k]);
            in_valid = 1'b0;
            check_wb($sformatf("t4.wb%0d", k), 5'(10 + k), f_exp[k]);
            check($sformatf("t4.occ%0d", k), occupancy, 3'(3 - k));
            check($sformatf("t4.rdy%0d", k), in_ready, 1);
        end
        tick();
        check("t4.idle", wb_valid, 0);

        // 5: stray response sets sticky error
        resp(32'h5555_5555);
        check("t5.err", resp_err, 1);
        check("t5.no_wb", wb_valid, 0);
        tick();
        check("t5.sticky", resp_err, 1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("t5.cleared", resp_err, 0);

        // 6: reset discards pending entries
        for (int k = 0; k < 3; k++) push(1, 1, 2'b10, 0, 0, 32'h400, 1, 5'(20 + k));
        check("t6.occ", occupancy, 3);
        rst = 1'b1; tick();
        check("t6.occ_rst", occupancy, 0);
        check("t6.wb_rst", wb_valid, 0);
        rst = 1'b0; #1;
        check("t6.ready", in_ready, 1);
        resp(32'h1111_1111);
        check("t6.no_retire", wb_valid, 0);
        check("t6.stray", resp_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
